// File: rtl/ram_nr1w_pkg.sv
// Shared types for the NUM_RD-read / 1-write synchronous RAM with bypass.
// Build option: RAM_NR1W_SYNC_BYPASS_WR_FWD_EN selects forwarding plus the
// coherent held response. When it is undefined, the RAM uses the legacy
// collision-stall behaviour.
package ram_nr1w_pkg;

  localparam int MAX_NUM_RD = 8;

  // Per-port response state:
  //   RD_IDLE  - no response pending
  //   RD_FRESH - first cycle of a response, data comes from the bank or the forward path
  //   RD_HELD  - response backpressured, data comes from the hold register
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FRESH = 2'd1,
    RD_HELD  = 2'd2
  } rd_out_state_e;

endpackage

// File: rtl/ram_1r1w_sync.sv
// Simple 1-read/1-write synchronous RAM bank.
// A read of an address that is written in the same cycle returns the old
// data. The read-port wrapper resolves that case.
module ram_1r1w_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read, only updated on an accepted request
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ram_nr1w_rd_port.sv
// One independent read port: private bank replica, request/response
// handshake, forward registers, hold register and IDLE/FRESH/HELD tracking.
// Build option: RAM_NR1W_SYNC_BYPASS_WR_FWD_EN (forwarding + coherent hold).
module ram_nr1w_rd_port
  import ram_nr1w_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_en,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_rdy,
  output logic              resp_val,
  output logic [DATA_W-1:0] resp_data,
  input  logic              resp_rdy
);

  rd_out_state_e     state;
  logic              stall;
  logic              accept;
  logic              wr_hit_req;
  logic              hold_load;
  logic [DATA_W-1:0] hold_nxt;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] bank_q;
  logic [DATA_W-1:0] out_data;

  assign wr_hit_req = wr_en && (wr_addr == req_addr);
  assign resp_val   = (state != RD_IDLE);
  assign stall      = resp_val & ~resp_rdy;
  assign accept     = req_en & req_rdy;
  assign resp_data  = out_data;

  ram_1r1w_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (accept),
    .rd_addr (req_addr),
    .rd_data (bank_q)
  );

`ifdef RAM_NR1W_SYNC_BYPASS_WR_FWD_EN
  logic              fwd_vld;
  logic [DATA_W-1:0] fwd_data;
  logic [ADDR_W-1:0] resp_addr;
  logic              wr_hit_resp;

  // The bank returns stale data on a same-cycle write, so a colliding
  // request is accepted and the write data is carried alongside it instead
  assign req_rdy = ~stall;

  // Forward flag: set when the accepted request hit the concurrent write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fwd_vld <= 1'b0;
    else if (accept) fwd_vld <= wr_hit_req;
  end

  // Forward data and response address captured with each accepted request
  always_ff @(posedge clk) begin
    if (accept) begin
      fwd_data  <= wr_data;
      resp_addr <= req_addr;
    end
  end

  // A write to the pending response's address refreshes the held value,
  // including a write that lands in the FRESH cycle itself
  assign wr_hit_resp = wr_en && (wr_addr == resp_addr);
  assign out_data    = (state == RD_FRESH) ? (fwd_vld ? fwd_data : bank_q) : hold;
  assign hold_load   = (state == RD_FRESH) | (stall & wr_hit_resp);
  assign hold_nxt    = (stall & wr_hit_resp) ? wr_data : out_data;
`else
  // Legacy: a request that collides with the write waits one cycle
  assign req_rdy   = ~stall & ~wr_hit_req;
  assign out_data  = (state == RD_FRESH) ? bank_q : hold;
  assign hold_load = (state == RD_FRESH);
  assign hold_nxt  = bank_q;
`endif

  // Hold register: captures the response at the end of its first cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         hold <= '0;
    else if (hold_load) hold <= hold_nxt;
  end

  // Response state: IDLE -> FRESH on accept, FRESH -> HELD on stall,
  // back to FRESH on handshake with a new accept, else IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RD_IDLE;
    end else begin
      case (state)
        RD_IDLE: begin
          if (accept) state <= RD_FRESH;
        end
        RD_FRESH, RD_HELD: begin
          if (stall)       state <= RD_HELD;
          else if (accept) state <= RD_FRESH;
          else             state <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ram_nr1w_sync_bypass.sv
// NUM_RD read ports and one write port built on replicated 1R1W banks.
// Each port has an independent valid/ready response with backpressure.
// Build option: define RAM_NR1W_SYNC_BYPASS_WR_FWD_EN for write-to-read
// forwarding and a held response that tracks writes. Leave it undefined for
// the legacy collision-stall behaviour.
module ram_nr1w_sync_bypass
  import ram_nr1w_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en_a,
  input  logic [ADDR_W-1:0]              wr_addr_a,
  input  logic [DATA_W-1:0]              wr_data_a,
  output logic                           wr_rdy_a,
  input  logic [NUM_RD-1:0]              rd_req_en_a,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_req_addr_a,
  output logic [NUM_RD-1:0]              rd_req_rdy_a,
  output logic [NUM_RD-1:0]              rd_resp_val_a,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_resp_data_a,
  input  logic [NUM_RD-1:0]              rd_resp_rdy_a
);

  if (NUM_RD < 1 || NUM_RD > MAX_NUM_RD) begin : g_bad_num_rd
    $error("NUM_RD out of range 1..MAX_NUM_RD");
  end

  // Writes never stall; every bank replica takes the same write
  assign wr_rdy_a = 1'b1;

`ifndef SYNTHESIS
  a_wr_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en_a |-> (32'(wr_addr_a) < DEPTH));
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    ram_nr1w_rd_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en_a),
      .wr_addr   (wr_addr_a),
      .wr_data   (wr_data_a),
      .req_en    (rd_req_en_a[i]),
      .req_addr  (rd_req_addr_a[i]),
      .req_rdy   (rd_req_rdy_a[i]),
      .resp_val  (rd_resp_val_a[i]),
      .resp_data (rd_resp_data_a[i]),
      .resp_rdy  (rd_resp_rdy_a[i])
    );

`ifndef SYNTHESIS
    a_rd_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
      rd_req_en_a[i] |-> (32'(rd_req_addr_a[i]) < DEPTH));
`endif
  end

endmodule

// File: tb/tb_ram_nr1w_sync_bypass.sv
// Directed bench for ram_nr1w_sync_bypass (DATA_W=32, DEPTH=64, NUM_RD=2).
// Expectations follow RAM_NR1W_SYNC_BYPASS_WR_FWD_EN when it is defined,
// else the legacy collision-stall behaviour.
module tb_ram_nr1w_sync_bypass;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en_a;
  logic [5:0]       wr_addr_a;
  logic [31:0]      wr_data_a;
  logic             wr_rdy_a;
  logic [1:0]       rd_req_en_a;
  logic [1:0][5:0]  rd_req_addr_a;
  logic [1:0]       rd_req_rdy_a;
  logic [1:0]       rd_resp_val_a;
  logic [1:0][31:0] rd_resp_data_a;
  logic [1:0]       rd_resp_rdy_a;

  int n_tests = 0;
  int n_fail  = 0;

  ram_nr1w_sync_bypass #(
    .DATA_W (32),
    .DEPTH  (64),
    .NUM_RD (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_a        (wr_en_a),
    .wr_addr_a      (wr_addr_a),
    .wr_data_a      (wr_data_a),
    .wr_rdy_a       (wr_rdy_a),
    .rd_req_en_a    (rd_req_en_a),
    .rd_req_addr_a  (rd_req_addr_a),
    .rd_req_rdy_a   (rd_req_rdy_a),
    .rd_resp_val_a  (rd_resp_val_a),
    .rd_resp_data_a (rd_resp_data_a),
    .rd_resp_rdy_a  (rd_resp_rdy_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [5:0]  a0;
    logic [5:0]  a1;
    logic [1:0]  rr;
    logic [1:0]  e_rq;
    logic [1:0]  e_v;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [1:0]  cd;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic we, logic [5:0] wa, logic [31:0] wd,
                              logic [1:0] re, logic [5:0] a0, logic [5:0] a1,
                              logic [1:0] rr, logic [1:0] e_rq, logic [1:0] e_v,
                              logic [31:0] e_d0, logic [31:0] e_d1, logic [1:0] cd);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.a0 = a0; v.a1 = a1; v.rr = rr;
    v.e_rq = e_rq; v.e_v = e_v; v.e_d0 = e_d0; v.e_d1 = e_d1; v.cd = cd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic [1:0] re, input logic [5:0] a0, input logic [5:0] a1,
                       input logic [1:0] rr);
    wr_en_a          = we;
    wr_addr_a        = wa;
    wr_data_a        = wd;
    rd_req_en_a      = re;
    rd_req_addr_a[0] = a0;
    rd_req_addr_a[1] = a1;
    rd_resp_rdy_a    = rr;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] e_rq, input logic [1:0] e_v,
                            input logic [31:0] e_d0, input logic [31:0] e_d1, input logic [1:0] cd);
    check({tag, " req_rdy"}, 32'(rd_req_rdy_a), 32'(e_rq));
    check({tag, " resp_val"}, 32'(rd_resp_val_a), 32'(e_v));
    if (cd[0]) check({tag, " data0"}, rd_resp_data_a[0], e_d0);
    if (cd[1]) check({tag, " data1"}, rd_resp_data_a[1], e_d1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and prefill
    rst_n = 1'b1;
    drive(1'b0, 6'd0, 32'h0, 2'b00, 6'd0, 6'd0, 2'b11);
    #2 rst_n = 1'b0;
    tick();
    #2 expect_out("in_reset", 2'b11, 2'b00, 32'h0, 32'h0, 2'b11);
    tick();
    rst_n = 1'b1;
    #2 expect_out("after_reset", 2'b11, 2'b00, 32'h0, 32'h0, 2'b11);
    check("wr_rdy", 32'(wr_rdy_a), 32'd1);
    tick();

    for (int a = 0; a < 8; a++) begin
      if (a != 5) begin
        drive(1'b1, 6'(a), (a == 3) ? 32'h0000_0003 : (32'hC0DE_0000 | 32'(a)),
              2'b00, 6'd0, 6'd0, 2'b11);
        tick();
      end
    end
    drive(1'b1, 6'd9, 32'h0000_9999, 2'b00, 6'd0, 6'd0, 2'b11);
    tick();

    // Common behaviour: basic read, then streaming on port 0 with stall on port 1
    //             we    wa     wd            re     a0     a1     rr     e_rq   e_v    e_d0          e_d1          cd
    tbl[0]  = mk(1'b1, 6'd5, 32'h0000_A5A5, 2'b00, 6'd0, 6'd0, 2'b11, 2'b11, 2'b00, 32'h0,        32'h0,        2'b00);
    tbl[1]  = mk(1'b0, 6'd0, 32'h0,         2'b01, 6'd5, 6'd0, 2'b11, 2'b11, 2'b00, 32'h0,        32'h0,        2'b00);
    tbl[2]  = mk(1'b0, 6'd0, 32'h0,         2'b00, 6'd0, 6'd0, 2'b11, 2'b11, 2'b01, 32'h0000_A5A5, 32'h0,       2'b01);
    tbl[3]  = mk(1'b0, 6'd0, 32'h0,         2'b11, 6'd0, 6'd3, 2'b11, 2'b11, 2'b00, 32'h0,        32'h0,        2'b00);
    tbl[4]  = mk(1'b0, 6'd0, 32'h0,         2'b01, 6'd1, 6'd0, 2'b01, 2'b01, 2'b11, 32'hC0DE_0000, 32'h0000_0003, 2'b11);
    tbl[5]  = mk(1'b0, 6'd0, 32'h0,         2'b01, 6'd2, 6'd0, 2'b01, 2'b01, 2'b11, 32'hC0DE_0001, 32'h0000_0003, 2'b11);
    tbl[6]  = mk(1'b0, 6'd0, 32'h0,         2'b01, 6'd3, 6'd0, 2'b01, 2'b01, 2'b11, 32'hC0DE_0002, 32'h0000_0003, 2'b11);
    tbl[7]  = mk(1'b0, 6'd0, 32'h0,         2'b01, 6'd4, 6'd0, 2'b01, 2'b01, 2'b11, 32'h0000_0003, 32'h0000_0003, 2'b11);
    tbl[8]  = mk(1'b0, 6'd0, 32'h0,         2'b01, 6'd5, 6'd0, 2'b11, 2'b11, 2'b11, 32'hC0DE_0004, 32'h0000_0003, 2'b11);
    tbl[9]  = mk(1'b0, 6'd0, 32'h0,         2'b01, 6'd6, 6'd0, 2'b11, 2'b11, 2'b01, 32'h0000_A5A5, 32'h0,       2'b01);
    tbl[10] = mk(1'b0, 6'd0, 32'h0,         2'b01, 6'd7, 6'd0, 2'b11, 2'b11, 2'b01, 32'hC0DE_0006, 32'h0,       2'b01);
    tbl[11] = mk(1'b0, 6'd0, 32'h0,         2'b00, 6'd0, 6'd0, 2'b11, 2'b11, 2'b01, 32'hC0DE_0007, 32'h0,       2'b01);
    tbl[12] = mk(1'b0, 6'd0, 32'h0,         2'b00, 6'd0, 6'd0, 2'b11, 2'b11, 2'b00, 32'h0,        32'h0,        2'b00);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].a0, tbl[i].a1, tbl[i].rr);
      #2 expect_out($sformatf("row%0d", i), tbl[i].e_rq, tbl[i].e_v, tbl[i].e_d0, tbl[i].e_d1, tbl[i].cd);
      tick();
    end

    // Collision: write 9 while both ports read 9
    drive(1'b1, 6'd9, 32'h0000_1234, 2'b11, 6'd9, 6'd9, 2'b11);
`ifdef RAM_NR1W_SYNC_BYPASS_WR_FWD_EN
    #2 expect_out("coll_req", 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    drive(1'b0, 6'd0, 32'h0, 2'b00, 6'd0, 6'd0, 2'b11);
    #2 expect_out("coll_resp", 2'b11, 2'b11, 32'h0000_1234, 32'h0000_1234, 2'b11);
    tick();
`else
    #2 expect_out("coll_req", 2'b00, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    drive(1'b0, 6'd0, 32'h0, 2'b11, 6'd9, 6'd9, 2'b11);
    #2 expect_out("coll_retry", 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    drive(1'b0, 6'd0, 32'h0, 2'b00, 6'd0, 6'd0, 2'b11);
    #2 expect_out("coll_resp", 2'b11, 2'b11, 32'h0000_1234, 32'h0000_1234, 2'b11);
    tick();
`endif
    #2 expect_out("coll_done", 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();

    // Coherent hold: port 1 stalls on addr 3 while addr 3 is rewritten
    drive(1'b0, 6'd0, 32'h0, 2'b10, 6'd0, 6'd3, 2'b01);
    #2 expect_out("coh_req", 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    drive(1'b1, 6'd3, 32'h0000_BEEF, 2'b00, 6'd0, 6'd0, 2'b01);
    #2 expect_out("coh_fresh", 2'b01, 2'b10, 32'h0, 32'h0000_0003, 2'b10);
    tick();
    drive(1'b1, 6'd4, 32'h0000_4444, 2'b00, 6'd0, 6'd0, 2'b01);
`ifdef RAM_NR1W_SYNC_BYPASS_WR_FWD_EN
    #2 expect_out("coh_held1", 2'b01, 2'b10, 32'h0, 32'h0000_BEEF, 2'b10);
    tick();
    drive(1'b1, 6'd3, 32'h0000_CAFE, 2'b00, 6'd0, 6'd0, 2'b01);
    #2 expect_out("coh_held2", 2'b01, 2'b10, 32'h0, 32'h0000_BEEF, 2'b10);
    tick();
    drive(1'b0, 6'd0, 32'h0, 2'b00, 6'd0, 6'd0, 2'b11);
    #2 expect_out("coh_held3", 2'b11, 2'b10, 32'h0, 32'h0000_CAFE, 2'b10);
    tick();
`else
    #2 expect_out("coh_held1", 2'b01, 2'b10, 32'h0, 32'h0000_0003, 2'b10);
    tick();
    drive(1'b1, 6'd3, 32'h0000_CAFE, 2'b00, 6'd0, 6'd0, 2'b01);
    #2 expect_out("coh_held2", 2'b01, 2'b10, 32'h0, 32'h0000_0003, 2'b10);
    tick();
    drive(1'b0, 6'd0, 32'h0, 2'b00, 6'd0, 6'd0, 2'b11);
    #2 expect_out("coh_held3", 2'b11, 2'b10, 32'h0, 32'h0000_0003, 2'b10);
    tick();
`endif
    #2 expect_out("coh_done", 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();

    // Asynchronous reset with two responses pending
    drive(1'b0, 6'd0, 32'h0, 2'b11, 6'd5, 6'd7, 2'b00);
    #2 expect_out("rst_req", 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    drive(1'b0, 6'd0, 32'h0, 2'b00, 6'd5, 6'd7, 2'b00);
    #2 expect_out("rst_pending", 2'b00, 2'b11, 32'h0000_A5A5, 32'hC0DE_0007, 2'b11);
    #1 rst_n = 1'b0;
    #1 expect_out("rst_async", 2'b11, 2'b00, 32'h0, 32'h0, 2'b11);
    drive(1'b0, 6'd0, 32'h0, 2'b11, 6'd5, 6'd7, 2'b11);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 6'd0, 32'h0, 2'b00, 6'd0, 6'd0, 2'b11);
    #2 expect_out("rst_no_resp", 2'b11, 2'b00, 32'h0, 32'h0, 2'b11);
    tick();
    drive(1'b0, 6'd0, 32'h0, 2'b11, 6'd5, 6'd7, 2'b11);
    tick();
    drive(1'b0, 6'd0, 32'h0, 2'b00, 6'd0, 6'd0, 2'b11);
    #2 expect_out("rst_mem_kept", 2'b11, 2'b11, 32'h0000_A5A5, 32'hC0DE_0007, 2'b11);
    tick();
    #2 expect_out("rst_end", 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
